reg_file_param: RTL and testbench
=================================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning word width in bits; legal values are multiples of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning entry 0 reads 0 and ignores writes.
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning same-cycle write data is forwarded to read ports.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 clr_req  input  1  request a full-array clear.
REQ-008 busy  output  1  high while the clear sequence runs.
REQ-009 wr_en  input  1  write enable.
REQ-010 w_adr  input  ADDR_W  write address.
REQ-011 w_data  input  DATA_W  write data.
REQ-012 w_be  input  DATA_W/8  byte enables; bit i covers w_data[8i+7:8i].
REQ-013 adr1, adr2  input  ADDR_W each  read addresses.
REQ-014 rs1, rs2  output  DATA_W each  combinational read data.

Function
REQ-015 The block SHALL have FSM states IDLE and CLEAR, plus a clear counter clr_cnt of ADDR_W bits.
REQ-016 In CLEAR, the block SHALL write 0 to entry clr_cnt and increment clr_cnt each cycle.
REQ-017 After clearing entry DEPTH-1, the block SHALL enter IDLE on the next edge; the full clear therefore takes exactly DEPTH cycles.
REQ-018 busy SHALL equal 1 exactly when the state is CLEAR.
REQ-019 When clr_req=1 in IDLE, the block SHALL enter CLEAR on the next edge with clr_cnt=0.
REQ-020 clr_req asserted while in CLEAR SHALL be ignored; it neither restarts nor extends the clear.
REQ-021 In IDLE with wr_en=1, each byte of entry w_adr whose w_be bit is 1 SHALL take the matching w_data byte at the edge; all other bytes SHALL be unchanged.
REQ-022 If wr_en=1 and w_be is all zeros, the block SHALL leave the array unchanged.
REQ-023 If ZERO_REG=1, a write to address 0 SHALL be dropped and rs1/rs2 SHALL read 0 for address 0.
REQ-024 Writes SHALL be dropped while busy=1.
REQ-025 If clr_req=1 and wr_en=1 in the same IDLE cycle, the clear SHALL win and the write SHALL be dropped.
REQ-026 While busy=1, rs1 and rs2 SHALL both read 0.
REQ-027 Otherwise, rsN SHALL equal stored entry adrN.
REQ-028 Bypass SHALL apply when BYPASS=1, IDLE, wr_en=1, clr_req=0, adrN==w_adr, and the address is not a dropped zero-register write.
REQ-029 Under bypass, rsN SHALL show the byte-merged value that will be stored at the next edge.
REQ-030 If BYPASS=0, rsN SHALL show the pre-write stored value.
REQ-031 adr1 and adr2 SHALL be independent and may be equal; both ports SHALL then return identical data.

Reset
REQ-032 Asserting rst SHALL immediately force state CLEAR, clr_cnt=0 and busy=1, without waiting for a clock edge.
REQ-033 While rst=1, rs1 and rs2 SHALL read 0 and the array SHALL not be written.
REQ-034 After rst deasserts, the clear SHALL proceed per REQ-016..017, so the array is all zero DEPTH cycles after the first edge.
REQ-035 rst asserted during an active clear SHALL restart the clear from entry 0.
REQ-036 Array contents SHALL not need a reset value other than through the clear sequence.

Verification
REQ-037 Reset release: with default parameters, busy SHALL stay high exactly 32 cycles, then fall; all 32 entries SHALL read 0.
REQ-038 Byte write: write 0xAABBCCDD to entry 5 with w_be=1111, then 0x11223344 with w_be=0101 -> entry 5 SHALL read 0xAA22CC44.
REQ-039 Bypass: with adr1=7, write 0xDEADBEEF to entry 7 with w_be=1111 -> rs1 SHALL read 0xDEADBEEF in the same cycle; with BYPASS=0, rs1 SHALL show the old value until after the edge.
REQ-040 Zero register: write 0xFFFFFFFF to entry 0 -> rs1 and rs2 with address 0 SHALL read 0.
REQ-041 Clear vs write: clr_req=1 and a write to entry 3 in the same cycle -> write dropped, busy high 32 cycles; a second clr_req mid-clear SHALL not extend busy.
REQ-042 Mid-clear reset: assert rst at clr_cnt=10 -> busy stays high, clear restarts at 0, and busy SHALL fall 32 cycles after rst release.

Source files
------------

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//
// Parameterised register file with two combinational read ports, one
// byte-enabled write port, an optional hard-wired zero entry, optional
// write-to-read forwarding and a self-timed clear sequence that zeroes the
// whole array one entry per clock.
//
// Parameters
//   DATA_W    word width in bits (multiple of 8)
//   ADDR_W    address width, DEPTH = 2**ADDR_W entries
//   ZERO_REG  1: entry 0 always reads 0 and ignores writes
//   BYPASS    1: same-cycle write data is forwarded to matching read ports
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous active-high reset (starts a clear)
//   clr_req  in   request a full-array clear
//   busy     out  high while the clear sequence runs
//   wr_en    in   write enable
//   w_adr    in   write address
//   w_data   in   write data
//   w_be     in   byte enables, bit i covers w_data[8i+7:8i]
//   adr1/2   in   read addresses
//   rs1/2    out  combinational read data
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    output logic                busy,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   w_adr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_be,
    input  logic [ADDR_W-1:0]   adr1,
    input  logic [ADDR_W-1:0]   adr2,
    output logic [DATA_W-1:0]   rs1,
    output logic [DATA_W-1:0]   rs2
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    // Storage has no reset; the clear sequence is the only way to zero it.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic              zero_hit;
    logic              wr_ok;
    logic              byp_ok;

    assign busy = (state_q == CLEAR);

    // ---------------- clear sequencer ----------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                // clr_req is deliberately not looked at here: a request
                // during a clear neither restarts nor extends it.
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // ---------------- write path ----------------
    // Read-modify-write merge: the same merged word feeds both the array
    // and the forwarding path, so forwarded data always matches what lands.
    assign w_old = mem[w_adr];

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_merge
            assign w_merged[8*gi +: 8] = w_be[gi] ? w_data[8*gi +: 8]
                                                  : w_old[8*gi +: 8];
        end
    endgenerate

    assign zero_hit = (ZERO_REG != 0) && (w_adr == '0);
    // Clear request wins over a simultaneous write.
    assign byp_ok   = (BYPASS != 0) && (state_q == IDLE) && wr_en
                      && !clr_req && !zero_hit;
    assign wr_ok    = (state_q == IDLE) && wr_en && !clr_req && !zero_hit
                      && (|w_be);

    // rst is sampled as plain data here so that no edge during reset
    // touches the array, even though the sequencer already sits in CLEAR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) begin
                mem[clr_cnt_q] <= '0;
            end else if (wr_ok) begin
                mem[w_adr] <= w_merged;
            end
        end
    end

    // ---------------- read ports ----------------
    logic [ADDR_W-1:0] rd_adr  [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_adr[0] = adr1;
    assign rd_adr[1] = adr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            assign rd_data[gi] =
                (busy || ((ZERO_REG != 0) && (rd_adr[gi] == '0))) ? '0 :
                (byp_ok && (rd_adr[gi] == w_adr))                 ? w_merged :
                                                                    mem[rd_adr[gi]];
        end
    endgenerate

    assign rs1 = rd_data[0];
    assign rs2 = rd_data[1];

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
//
// Directed bench for reg_file_param. Two instances share all inputs: dut_a
// uses default parameters (forwarding on), dut_b has forwarding off, so the
// same stimulus exercises both read behaviours. Inputs change on the falling
// edge; outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_req;
    logic        wr_en;
    logic [4:0]  w_adr;
    logic [31:0] w_data;
    logic [3:0]  w_be;
    logic [4:0]  adr1;
    logic [4:0]  adr2;

    logic        busy_a, busy_b;
    logic [31:0] rs1_a, rs2_a, rs1_b, rs2_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_file_param dut_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
        .wr_en(wr_en), .w_adr(w_adr), .w_data(w_data), .w_be(w_be),
        .adr1(adr1), .adr2(adr2), .rs1(rs1_a), .rs2(rs2_a)
    );

    reg_file_param #(.BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
        .wr_en(wr_en), .w_adr(w_adr), .w_data(w_data), .w_be(w_be),
        .adr1(adr1), .adr2(adr2), .rs1(rs1_b), .rs2(rs2_b)
    );

    // One full write cycle, returns on the following falling edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        wr_en  = 1'b1;
        w_adr  = a;
        w_data = d;
        w_be   = be;
        @(negedge clk);
        wr_en  = 1'b0;
        w_be   = 4'h0;
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b0; clr_req = 1'b0; wr_en = 1'b0; w_adr = '0;
        w_data = '0; w_be = '0; adr1 = 5'd7; adr2 = 5'd9;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy_a, busy_b} !== 2'b11) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 11", {busy_a, busy_b});
        end else $display("ok   reset_busy");
        n_checks++;
        if ({rs1_a, rs2_a, rs1_b, rs2_b} !== 128'h0) begin
            n_fail++; $display("FAIL reset_read0: got %h %h expected 0", rs1_a, rs1_b);
        end else $display("ok   reset_read0");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n != 32 || busy_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_len: got %0d cycles (busy_b=%b) expected 32", n, busy_b);
        end else $display("ok   reset_busy_len 32");
        for (int i = 0; i < 32; i++) begin
            adr1 = 5'(i);
            adr2 = 5'(31 - i);
            #1;
            n_checks++;
            if ({rs1_a, rs2_a, rs1_b, rs2_b} !== 128'h0) begin
                n_fail++; $display("FAIL reset_entry%0d: got %h %h expected 0", i, rs1_a, rs1_b);
            end else $display("ok   reset_entry%0d", i);
            @(negedge clk);
        end
    endtask

    task automatic test_byte_write;
        wr(5'd5, 32'hAABBCCDD, 4'hF);
        wr(5'd5, 32'h11223344, 4'h5);
        adr1 = 5'd5;
        #1;
        n_checks++;
        if (rs1_a !== 32'hAA22CC44 || rs1_b !== 32'hAA22CC44) begin
            n_fail++; $display("FAIL byte_write: got %h %h expected aa22cc44", rs1_a, rs1_b);
        end else $display("ok   byte_write");
        wr(5'd5, 32'hFFFFFFFF, 4'h0);
        #1;
        n_checks++;
        if (rs1_a !== 32'hAA22CC44 || rs1_b !== 32'hAA22CC44) begin
            n_fail++; $display("FAIL be_zero: got %h %h expected aa22cc44", rs1_a, rs1_b);
        end else $display("ok   be_zero");
    endtask

    task automatic test_bypass;
        wr(5'd7, 32'h12345678, 4'hF);
        adr1 = 5'd7;
        wr_en = 1'b1; w_adr = 5'd7; w_data = 32'hDEADBEEF; w_be = 4'hF;
        #1;
        n_checks++;
        if (rs1_a !== 32'hDEADBEEF || rs1_b !== 32'h12345678) begin
            n_fail++; $display("FAIL bypass_full: got %h %h expected deadbeef 12345678", rs1_a, rs1_b);
        end else $display("ok   bypass_full");
        @(negedge clk);
        wr_en = 1'b0; w_be = 4'h0;
        #1;
        n_checks++;
        if (rs1_a !== 32'hDEADBEEF || rs1_b !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL bypass_after: got %h %h expected deadbeef", rs1_a, rs1_b);
        end else $display("ok   bypass_after");
        @(negedge clk);
        adr2 = 5'd7;
        wr_en = 1'b1; w_adr = 5'd7; w_data = 32'h0000AAAA; w_be = 4'h3;
        #1;
        n_checks++;
        if (rs2_a !== 32'hDEADAAAA || rs2_b !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL bypass_partial: got %h %h expected deadaaaa deadbeef", rs2_a, rs2_b);
        end else $display("ok   bypass_partial");
        @(negedge clk);
        wr_en = 1'b0; w_be = 4'h0;
        #1;
        n_checks++;
        if (rs1_b !== 32'hDEADAAAA || rs2_a !== 32'hDEADAAAA) begin
            n_fail++; $display("FAIL partial_stored: got %h %h expected deadaaaa", rs1_b, rs2_a);
        end else $display("ok   partial_stored");
    endtask

    task automatic test_zero_reg;
        @(negedge clk);
        adr1 = 5'd0; adr2 = 5'd0;
        wr_en = 1'b1; w_adr = 5'd0; w_data = 32'hFFFFFFFF; w_be = 4'hF;
        #1;
        n_checks++;
        if ({rs1_a, rs2_a, rs1_b, rs2_b} !== 128'h0) begin
            n_fail++; $display("FAIL zero_reg_bypass: got %h %h expected 0", rs1_a, rs2_a);
        end else $display("ok   zero_reg_bypass");
        @(negedge clk);
        wr_en = 1'b0; w_be = 4'h0;
        #1;
        n_checks++;
        if ({rs1_a, rs2_a, rs1_b, rs2_b} !== 128'h0) begin
            n_fail++; $display("FAIL zero_reg_read: got %h %h expected 0", rs1_a, rs2_a);
        end else $display("ok   zero_reg_read");
    endtask

    task automatic test_dual_read;
        @(negedge clk);
        adr1 = 5'd5; adr2 = 5'd5;
        #1;
        n_checks++;
        if (rs1_a !== 32'hAA22CC44 || rs2_a !== 32'hAA22CC44) begin
            n_fail++; $display("FAIL dual_same: got %h %h expected aa22cc44", rs1_a, rs2_a);
        end else $display("ok   dual_same");
        adr2 = 5'd7;
        #1;
        n_checks++;
        if (rs1_a !== 32'hAA22CC44 || rs2_a !== 32'hDEADAAAA) begin
            n_fail++; $display("FAIL dual_diff: got %h %h expected aa22cc44 deadaaaa", rs1_a, rs2_a);
        end else $display("ok   dual_diff");
    endtask

    task automatic test_clear_vs_write;
        int n;
        wr(5'd3, 32'h33333333, 4'hF);
        adr1 = 5'd3;
        clr_req = 1'b1;
        wr_en = 1'b1; w_adr = 5'd3; w_data = 32'h55555555; w_be = 4'hF;
        #1;
        n_checks++;
        if (rs1_a !== 32'h33333333 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL clear_wins_nobypass: got %h busy=%b expected 33333333 busy=0", rs1_a, busy_a);
        end else $display("ok   clear_wins_nobypass");
        @(negedge clk);
        clr_req = 1'b0; wr_en = 1'b0; w_be = 4'h0;
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            if (n == 1) begin
                adr1 = 5'd7;
                #1;
                n_checks++;
                if (rs1_a !== 32'h0 || rs1_b !== 32'h0) begin
                    n_fail++; $display("FAIL busy_read0: got %h %h expected 0", rs1_a, rs1_b);
                end else $display("ok   busy_read0");
            end
            clr_req = (n == 5);
            wr_en   = (n == 10);
            w_adr   = 5'd2; w_data = 32'h22222222; w_be = 4'hF;
            @(negedge clk);
            n++;
        end
        clr_req = 1'b0; wr_en = 1'b0; w_be = 4'h0;
        n_checks++;
        if (n != 32 || busy_b !== 1'b0) begin
            n_fail++; $display("FAIL clear_len: got %0d cycles (busy_b=%b) expected 32", n, busy_b);
        end else $display("ok   clear_len 32");
        adr1 = 5'd3; adr2 = 5'd2;
        #1;
        n_checks++;
        if ({rs1_a, rs2_a, rs1_b, rs2_b} !== 128'h0) begin
            n_fail++; $display("FAIL clear_dropped: got %h %h expected 0", rs1_a, rs2_a);
        end else $display("ok   clear_dropped");
        adr1 = 5'd5; adr2 = 5'd7;
        #1;
        n_checks++;
        if ({rs1_a, rs2_a, rs1_b, rs2_b} !== 128'h0) begin
            n_fail++; $display("FAIL clear_zeroed: got %h %h expected 0", rs1_a, rs2_a);
        end else $display("ok   clear_zeroed");
    endtask

    task automatic test_async_reset;
        int n;
        wr(5'd20, 32'h20202020, 4'hF);
        wr(5'd31, 32'h31313131, 4'hF);
        adr1 = 5'd20; adr2 = 5'd31;
        #1;
        n_checks++;
        if (rs1_a !== 32'h20202020 || rs2_b !== 32'h31313131) begin
            n_fail++; $display("FAIL pre_reset: got %h %h expected 20202020 31313131", rs1_a, rs2_b);
        end else $display("ok   pre_reset");
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy_a, busy_b} !== 2'b11 || rs1_a !== 32'h0) begin
            n_fail++; $display("FAIL async_reset: got busy=%b rs1=%h expected 11 0", {busy_a, busy_b}, rs1_a);
        end else $display("ok   async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n != 32) begin
            n_fail++; $display("FAIL async_reset_len: got %0d cycles expected 32", n);
        end else $display("ok   async_reset_len 32");
        #1;
        n_checks++;
        if ({rs1_a, rs2_a, rs1_b, rs2_b} !== 128'h0) begin
            n_fail++; $display("FAIL async_reset_zeroed: got %h %h expected 0", rs1_a, rs2_a);
        end else $display("ok   async_reset_zeroed");
    endtask

    task automatic test_mid_clear_reset;
        int n;
        wr(5'd25, 32'h25252525, 4'hF);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++; $display("FAIL midclr_busy: got %b expected 1", busy_a);
        end else $display("ok   midclr_busy");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n != 32 || busy_b !== 1'b0) begin
            n_fail++; $display("FAIL midclr_len: got %0d cycles (busy_b=%b) expected 32", n, busy_b);
        end else $display("ok   midclr_len 32");
        adr1 = 5'd25; adr2 = 5'd5;
        #1;
        n_checks++;
        if ({rs1_a, rs2_a, rs1_b, rs2_b} !== 128'h0) begin
            n_fail++; $display("FAIL midclr_zeroed: got %h %h expected 0", rs1_a, rs1_b);
        end else $display("ok   midclr_zeroed");
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_bypass();
        test_zero_reg();
        test_dual_read();
        test_clear_vs_write();
        test_async_reset();
        test_mid_clear_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
